// File: rtl/regmem_xfer.sv
// Data memory plus register file with a command-driven burst transfer engine
// (LOAD mem->reg, STORE reg->mem, FILL constant->mem) and two registered host read ports.
module regmem_xfer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int REG_AW = 5,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_mem_addr,
    input  logic [REG_AW-1:0] cmd_reg_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int REG_NUM   = 1 << REG_AW;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [REG_AW-1:0] REG_ONE  = 1;
    localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_WR,
        XFER,
        DONE,
        ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [REG_AW-1:0]   regAddr_q, regAddr_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic                isFill_q, isFill_d;
    logic [DATA_W-1:0]   fillData_q, fillData_d;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];
    logic [DATA_W-1:0]   regs_q [REG_NUM];
    logic [DATA_W-1:0]   memRdData_q;
    logic [DATA_W-1:0]   rdData1_q, rdData2_q;

    logic                memWe;
    logic [DATA_W-1:0]   memWdata;
    logic                regWe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
        memAddr_q  <= memAddr_d;
        regAddr_q  <= regAddr_d;
        remain_q   <= remain_d;
        isFill_q   <= isFill_d;
        fillData_q <= fillData_d;
    end

    always_comb begin
        state_d    = state_q;
        memAddr_d  = memAddr_q;
        regAddr_d  = regAddr_q;
        remain_d   = remain_q;
        isFill_d   = isFill_q;
        fillData_d = fillData_q;
        memWe      = 1'b0;
        memWdata   = isFill_q ? fillData_q : regs_q[regAddr_q];
        regWe      = 1'b0;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    memAddr_d  = cmd_mem_addr;
                    regAddr_d  = cmd_reg_addr;
                    remain_d   = cmd_len;
                    isFill_d   = (cmd_op == 2'b10);
                    fillData_d = cmd_data;
                    case (cmd_op)
                        2'b00:   state_d = LD_RD;
                        2'b01,
                        2'b10:   state_d = XFER;
                        default: state_d = ERR;
                    endcase
                end
            end
            LD_RD: state_d = LD_WR;
            LD_WR, XFER: begin
                regWe     = (state_q == LD_WR);
                memWe     = (state_q == XFER);
                memAddr_d = memAddr_q + ADDR_ONE;
                regAddr_d = regAddr_q + REG_ONE;
                if (remain_q == '0) begin
                    state_d = DONE;
                end else begin
                    remain_d = remain_q - LEN_ONE;
                    state_d  = (state_q == LD_WR) ? LD_RD : XFER;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset dominates: no handshake, no status pulses and no writes at a reset edge
        if (rst) begin
            cmd_ready = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
            memWe     = 1'b0;
            regWe     = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr_q] <= memWdata;
        end
        memRdData_q <= mem[memAddr_q];
    end

    // Host reads sample the array before a same-edge LOAD write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            rdData1_q <= '0;
            rdData2_q <= '0;
        end else begin
            if (regWe) begin
                regs_q[regAddr_q] <= memRdData_q;
            end
            rdData1_q <= regs_q[rd_addr1];
            rdData2_q <= regs_q[rd_addr2];
        end
    end

    assign rd_data1 = rdData1_q;
    assign rd_data2 = rdData2_q;

endmodule

// File: tb/tb_regmem_xfer.sv
// Self-checking bench for regmem_xfer: directed scenarios plus randomized back-to-back
// commands checked against an array-based memory/register model.
module tb_regmem_xfer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_mem_addr;
    logic [4:0]  cmd_reg_addr;
    logic [3:0]  cmd_len;
    logic [31:0] cmd_data;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelMem [1024];
    logic [31:0] modelRegs [32];

    regmem_xfer #(.DATA_W(32), .ADDR_W(10), .REG_AW(5), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mem_addr(cmd_mem_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Issues one command from a negedge and reports, in cycles after acceptance, when done/err/cmd_ready appear
    task automatic runCmd(input logic [1:0] op, input logic [9:0] maddr, input logic [4:0] raddr,
                          input logic [3:0] len, input logic [31:0] data,
                          output int doneCnt, output int doneAt, output int errAt,
                          output int readyAt, output bit bothHigh);
        int w = 0;
        doneCnt = 0; doneAt = -1; errAt = -1; readyAt = -1; bothHigh = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("[TB] FAIL cmd_ready_wait: cmd_ready=%0b, required 1 within 50 cycles", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_mem_addr = maddr;
        cmd_reg_addr = raddr; cmd_len = len; cmd_data = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done && err) bothHigh = 1;
            if (done) begin
                doneCnt++;
                if (doneAt < 0) doneAt = n;
            end
            if (err && errAt < 0) errAt = n;
            if (cmd_ready) begin
                readyAt = n;
                break;
            end
        end
        if (readyAt < 0) begin
            errors++;
            $display("[TB] FAIL cmd_timeout: cmd_ready never returned, required within 100 cycles");
        end
        for (int k = 0; k <= int'(len); k++) begin
            case (op)
                2'b00: modelRegs[(int'(raddr) + k) % 32] = modelMem[(int'(maddr) + k) % 1024];
                2'b01: modelMem[(int'(maddr) + k) % 1024] = modelRegs[(int'(raddr) + k) % 32];
                2'b10: modelMem[(int'(maddr) + k) % 1024] = data;
                default: ;
            endcase
        end
    endtask

    task automatic readRegs(input logic [4:0] a1, input logic [4:0] a2,
                            output logic [31:0] d1, output logic [31:0] d2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        @(posedge clk);
        @(negedge clk);
        d1 = rd_data1;
        d2 = rd_data2;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mem_addr = '0;
        cmd_reg_addr = '0; cmd_len = '0; cmd_data = '0; rd_addr1 = 5'd3; rd_addr2 = 5'd17;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_status: ready/busy/done/err=%b, required 0000", {cmd_ready, busy, done, err});
        end
        checks++;
        if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: rd_data1=%h rd_data2=%h, required 0", rd_data1, rd_data2);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
    endtask

    task automatic initMemory;
        int dc, da, ea, ra;
        bit bh;
        for (int b = 0; b < 64; b++) begin
            runCmd(2'b10, 10'(b * 16), 5'd0, 4'd15, 32'd0, dc, da, ea, ra, bh);
        end
    endtask

    task automatic test_fill_load;
        int dc, da, ea, ra;
        bit bh;
        logic [31:0] d1, d2;
        runCmd(2'b10, 10'h010, 5'd0, 4'd3, 32'hDEADBEEF, dc, da, ea, ra, bh);
        checks++;
        if (dc !== 1 || da !== 5 || ra !== 6) begin
            errors++;
            $display("[TB] FAIL fill_timing: doneCnt=%0d doneAt=%0d readyAt=%0d, required 1 5 6", dc, da, ra);
        end
        runCmd(2'b00, 10'h010, 5'd4, 4'd3, 32'd0, dc, da, ea, ra, bh);
        checks++;
        if (dc !== 1 || da !== 9 || ra !== 10) begin
            errors++;
            $display("[TB] FAIL load_timing: doneCnt=%0d doneAt=%0d readyAt=%0d, required 1 9 10", dc, da, ra);
        end
        for (int r = 4; r < 8; r++) begin
            readRegs(5'(r), 5'(r), d1, d2);
            checks++;
            if (d1 !== 32'hDEADBEEF || d2 !== 32'hDEADBEEF || modelRegs[r] !== 32'hDEADBEEF) begin
                errors++;
                $display("[TB] FAIL fill_load_reg%0d: port1=%h port2=%h, required deadbeef", r, d1, d2);
            end
        end
    endtask

    task automatic test_store;
        int dc, da, ea, ra;
        bit bh;
        logic [31:0] d1, d2;
        runCmd(2'b10, 10'h100, 5'd0, 4'd0, 32'hA5A50001, dc, da, ea, ra, bh);
        runCmd(2'b10, 10'h101, 5'd0, 4'd0, 32'h5A5A0002, dc, da, ea, ra, bh);
        runCmd(2'b00, 10'h100, 5'd1, 4'd1, 32'd0, dc, da, ea, ra, bh);
        runCmd(2'b01, 10'h200, 5'd1, 4'd1, 32'd0, dc, da, ea, ra, bh);
        checks++;
        if (dc !== 1 || da !== 3 || ra !== 4) begin
            errors++;
            $display("[TB] FAIL store_timing: doneCnt=%0d doneAt=%0d readyAt=%0d, required 1 3 4", dc, da, ra);
        end
        runCmd(2'b00, 10'h200, 5'd20, 4'd1, 32'd0, dc, da, ea, ra, bh);
        readRegs(5'd20, 5'd1, d1, d2);
        checks++;
        if (d1 !== 32'hA5A50001 || d2 !== 32'hA5A50001) begin
            errors++;
            $display("[TB] FAIL store_reg20: reg20=%h reg1=%h, required a5a50001", d1, d2);
        end
        readRegs(5'd2, 5'd21, d1, d2);
        checks++;
        if (d1 !== 32'h5A5A0002 || d2 !== 32'h5A5A0002) begin
            errors++;
            $display("[TB] FAIL store_reg21: reg2=%h reg21=%h, required 5a5a0002", d1, d2);
        end
    endtask

    task automatic test_wrap;
        int dc, da, ea, ra;
        bit bh;
        logic [31:0] d1, d2;
        runCmd(2'b10, 10'h3FE, 5'd0, 4'd3, 32'h5, dc, da, ea, ra, bh);
        runCmd(2'b00, 10'h3FE, 5'd30, 4'd3, 32'd0, dc, da, ea, ra, bh);
        readRegs(5'd30, 5'd31, d1, d2);
        checks++;
        if (d1 !== 32'h5 || d2 !== 32'h5) begin
            errors++;
            $display("[TB] FAIL wrap_reg30_31: %h %h, required 5 5", d1, d2);
        end
        readRegs(5'd0, 5'd1, d1, d2);
        checks++;
        if (d1 !== 32'h5 || d2 !== 32'h5) begin
            errors++;
            $display("[TB] FAIL wrap_reg0_1: %h %h, required 5 5", d1, d2);
        end
        readRegs(5'd2, 5'd29, d1, d2);
        checks++;
        if (d1 !== modelRegs[2] || d2 !== modelRegs[29]) begin
            errors++;
            $display("[TB] FAIL wrap_neighbours: reg2=%h reg29=%h, required %h %h", d1, d2, modelRegs[2], modelRegs[29]);
        end
    endtask

    task automatic test_reserved;
        int dc, da, ea, ra;
        bit bh;
        logic [31:0] d1, d2;
        runCmd(2'b11, 10'h010, 5'd4, 4'd3, 32'h12345678, dc, da, ea, ra, bh);
        checks++;
        if (ea !== 1 || dc !== 0 || ra !== 2 || bh) begin
            errors++;
            $display("[TB] FAIL reserved_timing: errAt=%0d doneCnt=%0d readyAt=%0d, required 1 0 2", ea, dc, ra);
        end
        readRegs(5'd4, 5'd7, d1, d2);
        checks++;
        if (d1 !== 32'hDEADBEEF || d2 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL reserved_regs: reg4=%h reg7=%h, required deadbeef", d1, d2);
        end
        runCmd(2'b00, 10'h010, 5'd8, 4'd3, 32'd0, dc, da, ea, ra, bh);
        readRegs(5'd8, 5'd11, d1, d2);
        checks++;
        if (d1 !== 32'hDEADBEEF || d2 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL reserved_mem: reg8=%h reg11=%h, required deadbeef", d1, d2);
        end
    endtask

    task automatic test_reset_mid_load;
        int dc, da, ea, ra;
        bit bh, sawDone = 0;
        logic [31:0] d1, d2;
        int bad = 0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_mem_addr = 10'h100;
        cmd_reg_addr = 5'd12; cmd_len = 4'd7; cmd_data = '0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (done) sawDone = 1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) sawDone = 1;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || sawDone) begin
            errors++;
            $display("[TB] FAIL midreset_status: cmd_ready=%b sawDoneOrBusy=%0d, required 1 0", cmd_ready, sawDone);
        end
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        for (int r = 0; r < 16; r++) begin
            readRegs(5'(r), 5'(r + 16), d1, d2);
            if (d1 !== 32'd0 || d2 !== 32'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_regs: %0d nonzero pairs, required 0", bad);
        end
        runCmd(2'b10, 10'h040, 5'd0, 4'd2, 32'hCAFEF00D, dc, da, ea, ra, bh);
        checks++;
        if (dc !== 1 || da !== 4 || ra !== 5) begin
            errors++;
            $display("[TB] FAIL midreset_fill: doneCnt=%0d doneAt=%0d readyAt=%0d, required 1 4 5", dc, da, ra);
        end
    endtask

    task automatic test_read_during_write;
        int dc, da, ea, ra, w;
        bit bh;
        logic [31:0] oldV, newV, d1, d2;
        runCmd(2'b00, 10'h010, 5'd9, 4'd0, 32'd0, dc, da, ea, ra, bh);
        oldV = modelRegs[9];
        newV = ~oldV;
        runCmd(2'b10, 10'h300, 5'd0, 4'd0, newV, dc, da, ea, ra, bh);
        readRegs(5'd9, 5'd9, d1, d2);
        rd_addr1 = 5'd9;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_mem_addr = 10'h300;
        cmd_reg_addr = 5'd9; cmd_len = 4'd0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_data1 !== oldV) begin
            errors++;
            $display("[TB] FAIL rdw_old: rd_data1=%h, required %h", rd_data1, oldV);
        end
        @(negedge clk);
        checks++;
        if (rd_data1 !== newV) begin
            errors++;
            $display("[TB] FAIL rdw_new: rd_data1=%h, required %h", rd_data1, newV);
        end
        modelRegs[9] = newV;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_random_back_to_back;
        int dc, da, ea, ra, expDone, expReady, expErr, expDc, bad;
        bit bh;
        logic [1:0] op;
        logic [3:0] len;
        logic [31:0] d1, d2;
        for (int it = 0; it < 40; it++) begin
            op  = 2'($urandom_range(0, 3));
            len = 4'($urandom);
            runCmd(op, 10'($urandom), 5'($urandom), len, $urandom, dc, da, ea, ra, bh);
            case (op)
                2'b00:   begin expDc = 1; expDone = 2 * (int'(len) + 1) + 1; expErr = -1; expReady = expDone + 1; end
                2'b11:   begin expDc = 0; expDone = -1; expErr = 1; expReady = 2; end
                default: begin expDc = 1; expDone = int'(len) + 2; expErr = -1; expReady = expDone + 1; end
            endcase
            checks++;
            if (dc !== expDc || da !== expDone || ea !== expErr || ra !== expReady || bh) begin
                errors++;
                $display("[TB] FAIL rand_timing%0d: op=%0d len=%0d done=%0d/%0d at %0d err@%0d ready@%0d, required %0d at %0d err@%0d ready@%0d",
                         it, op, len, dc, bh, da, ea, ra, expDc, expDone, expErr, expReady);
            end
            if (it % 10 == 9) begin
                bad = 0;
                for (int r = 0; r < 16; r++) begin
                    readRegs(5'(r), 5'(r + 16), d1, d2);
                    if (d1 !== modelRegs[r] || d2 !== modelRegs[r + 16]) bad++;
                end
                checks++;
                if (bad !== 0) begin
                    errors++;
                    $display("[TB] FAIL rand_regs%0d: %0d register pairs differ from model, required 0", it, bad);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        initMemory();
        test_fill_load();
        test_store();
        test_wrap();
        test_reserved();
        test_reset_mid_load();
        test_read_during_write();
        test_random_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/regmem_xfer.md
# regmem_xfer

Parametrised data-memory plus register-file subsystem with a command-driven transfer engine. It moves bursts of words between memory and registers: LOAD copies memory to registers, STORE copies registers to memory, and FILL writes a constant into memory. Two registered host read ports expose the register file. It is the core datapath storage block that the top level instantiates in place of separate hand-wired memory and register-file paths.

## Interface
Parameters:
- DATA_W, 32, word width of memory and register file
- ADDR_W, 10, memory address width; memory depth 2^ADDR_W
- REG_AW, 5, register address width; 2^REG_AW registers
- LEN_W, 4, burst length field width; a burst is cmd_len+1 words (1..2^LEN_W)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle and able to accept a command
- cmd_op  in  2  00 LOAD (mem→reg), 01 STORE (reg→mem), 10 FILL (cmd_data→mem), 11 reserved
- cmd_mem_addr  in  ADDR_W  first memory address
- cmd_reg_addr  in  REG_AW  first register address
- cmd_len  in  LEN_W  word count minus one
- cmd_data  in  DATA_W  FILL constant
- rd_addr1  in  REG_AW  host read port 1 address
- rd_addr2  in  REG_AW  host read port 2 address
- rd_data1  out  DATA_W  register contents at rd_addr1, registered
- rd_data2  out  DATA_W  register contents at rd_addr2, registered
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on transfer completion
- err  out  1  one-cycle pulse on reserved opcode

## Operation
- Command acceptance:
  - A command is accepted on the edge where cmd_valid && cmd_ready.
  - All cmd_* fields are captured into internal registers at that edge.
  - Inputs are ignored while busy.
- FSM states:
  - IDLE: cmd_ready=1. Accept LOAD goes to LD_RD. Accept STORE or FILL goes to XFER. Accept op 11 goes to ERR.
  - LD_RD: issue a synchronous memory read at the current memory address, then go to LD_WR.
  - LD_WR: write the returned memory word to the current register. Increment both addresses and decrement the remaining count. Go to LD_RD if words remain, else to DONE.
  - XFER: write one word per cycle to memory at the current address. STORE writes reg[cur_reg]; FILL writes the captured cmd_data. Increment addresses. Go to DONE after the last word.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 for one cycle, then IDLE. No memory or register write occurs.
- Address arithmetic: the memory address wraps modulo 2^ADDR_W; the register address wraps modulo 2^REG_AW. There is no error on wrap.
- Memory: synchronous read with 1-cycle latency, one write per cycle. Contents are not cleared by rst.
- Register file: one internal write port (LOAD only) and three read paths (two host, one STORE). All registers are cleared to 0 by rst.
- Host read ports:
  - rd_dataN is updated every cycle, including while busy.
  - If the same-cycle LD_WR write targets rd_addrN, rd_dataN returns the old value (read-before-write); the new value is visible one cycle later.
- busy=1 in every state except IDLE.

## Timing
- Reset:
  - While rst=1: state=IDLE, cmd_ready=0, busy=0, done=0, err=0, rd_data1=rd_data2=0.
  - cmd_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: the FSM returns to IDLE at the next edge. Words already written stay written, and done is not pulsed.
- LOAD of N words accepted at edge E0:
  - Register k (0-based) is written at edge E0+2(k+1).
  - done is high in the cycle after edge E0+2N.
  - cmd_ready returns at edge E0+2N+2.
- STORE/FILL of N words accepted at E0:
  - Word k is written at edge E0+k+1.
  - done is high after edge E0+N.
  - cmd_ready returns at edge E0+N+2.
- Reserved op at E0: err is high in the cycle after E0, and cmd_ready returns at E0+2.
- A back-to-back command can be accepted in the first cycle cmd_ready=1. There is no bubble beyond DONE/ERR.
- done and err are never high in the same cycle.

## Test plan
- FILL: mem_addr=0x010, len=3, data=0xDEADBEEF; then LOAD to reg 4, len=3 → regs 4..7 read 0xDEADBEEF on both ports; done pulses once per command; LOAD done arrives 9 cycles after acceptance.
- STORE: preload regs 1..2 via LOAD of distinct words; STORE regs 1..2 to mem 0x200; LOAD 0x200..0x201 to regs 20..21 → regs 20..21 match regs 1..2 exactly.
- Wrap: FILL mem_addr=0x3FE, len=3, data=0x5 → addresses 0x3FE, 0x3FF, 0x000, 0x001 hold 0x5; LOAD with reg_addr=30, len=3 → regs 30, 31, 0, 1 are written.
- Reserved op 11: → err pulses 1 cycle after acceptance; done stays 0; memory and regs unchanged; cmd_ready back 2 cycles after acceptance.
- Reset mid-LOAD: assert rst after 2 words of an 8-word LOAD → registers read 0; no done pulse; cmd_ready=1 in the first cycle after rst deasserts; a new FILL completes normally.
- Read-during-write: hold rd_addr1 on the register being written by LD_WR → old value in the write cycle, new value exactly one cycle later.
